// File: rtl/swctl_pkg.sv
// Shared constants, state encoding and register read mux
// for the DIP switch IO controller.
package swctl_pkg;

    localparam logic [1:0] SWCTL_ADDR_LO   = 2'b00;
    localparam logic [1:0] SWCTL_ADDR_STAT = 2'b01;
    localparam logic [1:0] SWCTL_ADDR_HI   = 2'b10;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int SW_W = 24;
    localparam int RD_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } swctl_state_t;

    function automatic logic [RD_W-1:0] swctl_reg_read(
        input logic [SW_W-1:0] stable,
        input logic            changed,
        input logic [1:0]      addr
    );
        logic [RD_W-1:0] d;
        d = '0;
        unique case (1'b1)
            addr == SWCTL_ADDR_LO:   d = stable[15:0];
            addr == SWCTL_ADDR_HI:   d = {8'h00, stable[23:16]};
            addr == SWCTL_ADDR_STAT: d = {15'b0, changed};
            default:                 d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/switch_io_ctrl_debounce.sv
// Two-flop synchronizer plus saturating debounce counter;
// commit is high in the cycle a new stable value is taken.
module switch_debounce
    import swctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int CNT_W           = 18
) (
    input  logic            swctlclk,
    input  logic            swctlrst,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] stable,
    output logic            commit
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync1;
    logic [SW_W-1:0]  sync2;
    logic [SW_W-1:0]  cand;
    logic [CNT_W-1:0] cnt;
    logic             hold;
    logic             done;

    assign hold   = (sync2 == cand);
    assign done   = (cnt >= CNT_LAST);
    assign commit = hold && done && (cand != stable);

    always_ff @(posedge swctlclk or negedge swctlrst) begin
        if (!swctlrst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (!hold) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (!done) begin
                cnt <= cnt + 1'b1;
            end else if (commit) begin
                stable <= cand;
            end
        end
    end

endmodule

// File: rtl/switch_io_ctrl.sv
// Debounced switch snapshot with sticky change flag and a
// two-port round-robin req/ack read arbiter.
module switch_io_ctrl
    import swctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int CNT_W           = 18
) (
    input  logic            swctlclk,
    input  logic            swctlrst,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            req0,
    input  logic [1:0]      addr0,
    output logic [RD_W-1:0] rdata0,
    output logic            ack0,
    input  logic            req1,
    input  logic [1:0]      addr1,
    output logic [RD_W-1:0] rdata1,
    output logic            ack1,
    output logic            sw_changed
);

    logic [SW_W-1:0] stable;
    logic            commit;

    swctl_state_t    state;
    swctl_state_t    state_nx;
    logic            grant;
    logic            gnt_q;
    logic [1:0]      addr_q;
    logic            rr;
    logic            serve0;
    logic            serve1;
    logic            stat_clr;
    logic [RD_W-1:0] rd_mux;
    logic [RD_W-1:0] rdata0_q;
    logic [RD_W-1:0] rdata1_q;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .swctlclk(swctlclk),
        .swctlrst(swctlrst),
        .sw_raw  (sw_raw),
        .stable  (stable),
        .commit  (commit)
    );

    always_ff @(posedge swctlclk or negedge swctlrst) begin
        if (!swctlrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant    = PORT0;
        unique case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_nx = ST_SERVE;
                    grant    = (req0 && req1) ? rr : req1;
                end
            end
            ST_SERVE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        serve0   = (state == ST_SERVE) && (gnt_q == PORT0);
        serve1   = (state == ST_SERVE) && (gnt_q == PORT1);
        stat_clr = serve0 && (addr_q == SWCTL_ADDR_STAT);
        rd_mux   = swctl_reg_read(stable, sw_changed, addr_q);
        ack0     = serve0;
        ack1     = serve1;
        rdata0   = serve0 ? rd_mux : rdata0_q;
        rdata1   = serve1 ? rd_mux : rdata1_q;
    end

    // A commit landing on a status-read clear must win.
    always_ff @(posedge swctlclk or negedge swctlrst) begin
        if (!swctlrst) begin
            gnt_q      <= PORT0;
            addr_q     <= SWCTL_ADDR_LO;
            rr         <= PORT0;
            sw_changed <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if ((state == ST_IDLE) && (state_nx == ST_SERVE)) begin
                gnt_q  <= grant;
                addr_q <= grant ? addr1 : addr0;
            end
            if (serve0 || serve1) rr <= ~gnt_q;
            if (serve0) rdata0_q <= rd_mux;
            if (serve1) rdata1_q <= rd_mux;
            if (commit) begin
                sw_changed <= 1'b1;
            end else if (stat_clr) begin
                sw_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_io_ctrl.sv
// Directed and randomized checks of switch_io_ctrl against
// a behavioural model of debounce, flag and arbitration.
module tb_switch_io_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] sw_raw = '0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [1:0]  addr0 = 2'b00;
    logic [1:0]  addr1 = 2'b00;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        ack0;
    logic        ack1;
    logic        sw_changed;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    switch_io_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (18)
    ) dut (
        .swctlclk  (clk),
        .swctlrst  (rst),
        .sw_raw    (sw_raw),
        .req0      (req0),
        .addr0     (addr0),
        .rdata0    (rdata0),
        .ack0      (ack0),
        .req1      (req1),
        .addr1     (addr1),
        .rdata1    (rdata1),
        .ack1      (ack1),
        .sw_changed(sw_changed)
    );

    // Reference model: a value commits once the synchronized input has
    // been identical for DEB+1 consecutive cycles and differs from stable.
    logic [23:0] h1 = '0, h2 = '0, pv = '0, m_stable = '0;
    int          run = 1;
    logic        m_chg = 0, m_busy = 0, m_gnt = 0, m_rr = 0;
    logic [1:0]  m_addr = 0;
    logic        m_ack0 = 0, m_ack1 = 0;
    logic [15:0] m_rd0 = 0, m_rd1 = 0;

    function automatic logic [15:0] m_reg(input logic [1:0] a);
        if (a == 2'b00) return m_stable[15:0];
        if (a == 2'b10) return {8'h00, m_stable[23:16]};
        if (a == 2'b01) return {15'b0, m_chg};
        return 16'h0000;
    endfunction

    initial begin : model
        logic [23:0] v;
        logic        cmt;
        logic        clr;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                h1 = '0; h2 = '0; pv = '0; run = 1;
                m_stable = '0; m_chg = 0; m_busy = 0; m_rr = 0;
                m_rd0 = '0; m_rd1 = '0;
            end else begin
                v = h2;
                if (v == pv) begin
                    if (run < DEB + 1) run = run + 1;
                end else begin
                    run = 1;
                end
                pv  = v;
                cmt = (run >= DEB + 1) && (v != m_stable);
                clr = m_busy && !m_gnt && (m_addr == 2'b01);
                if (m_busy) begin
                    m_rr   = ~m_gnt;
                    m_busy = 0;
                end else if (req0 || req1) begin
                    m_gnt  = (req0 && req1) ? m_rr : req1;
                    m_addr = m_gnt ? addr1 : addr0;
                    m_busy = 1;
                end
                if (cmt) m_stable = v;
                if (cmt) m_chg = 1;
                else if (clr) m_chg = 0;
                h2 = h1;
                h1 = sw_raw;
                if (m_busy && m_gnt) m_rd1 = m_reg(m_addr);
                if (m_busy && !m_gnt) m_rd0 = m_reg(m_addr);
            end
            m_ack0 = m_busy && !m_gnt;
            m_ack1 = m_busy && m_gnt;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic bus_read(input logic p, input logic [1:0] a,
                            output logic [15:0] d, output int lat);
        lat = -1;
        d   = 16'hxxxx;
        if (p) begin req1 = 1; addr1 = a; end
        else   begin req0 = 1; addr0 = a; end
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge clk);
            if ((p ? ack1 : ack0) === 1'b1) begin
                d   = p ? rdata1 : rdata0;
                lat = i;
            end
        end
        if (p) req1 = 0;
        else   req0 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({ack0, ack1, sw_changed, rdata0, rdata1} !== 35'd0) begin
            errs++;
            $display("FAIL reset_outputs got %h want 0",
                     {ack0, ack1, sw_changed, rdata0, rdata1});
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] d;
        int          lat;
        sw_raw = 24'hA5_1234;
        repeat (10) @(negedge clk);
        vec++;
        if (sw_changed !== 1'b1) begin
            errs++; $display("FAIL commit_flag got %b want 1", sw_changed);
        end
        bus_read(0, 2'b00, d, lat);
        vec++;
        if (d !== 16'h1234 || lat != 1) begin
            errs++; $display("FAIL rd_lo got %h lat %0d want 1234 lat 1", d, lat);
        end
        bus_read(0, 2'b10, d, lat);
        vec++;
        if (d !== 16'h00A5) begin
            errs++; $display("FAIL rd_hi got %h want 00a5", d);
        end
    endtask

    task automatic test_status();
        logic [15:0] d;
        int          lat;
        bus_read(1, 2'b01, d, lat);
        vec++;
        if (d !== 16'h0001 || sw_changed !== 1'b1) begin
            errs++; $display("FAIL p1_stat got %h flag %b want 0001 flag 1", d, sw_changed);
        end
        bus_read(0, 2'b01, d, lat);
        vec++;
        if (d !== 16'h0001 || sw_changed !== 1'b0) begin
            errs++; $display("FAIL p0_stat got %h flag %b want 0001 flag 0", d, sw_changed);
        end
        bus_read(0, 2'b01, d, lat);
        vec++;
        if (d !== 16'h0000) begin
            errs++; $display("FAIL p0_stat_again got %h want 0000", d);
        end
    endtask

    task automatic test_bounce();
        logic [15:0] d;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            sw_raw = (i % 2) ? 24'hF0F0F0 : 24'h0F0F0F;
            repeat (2) begin
                @(negedge clk);
                vec++;
                if (sw_changed !== 1'b0) begin
                    errs++; $display("FAIL bounce_flag i=%0d got %b want 0", i, sw_changed);
                end
            end
        end
        sw_raw = 24'h3C_5A69;
        bus_read(1, 2'b10, d, lat);
        vec++;
        if (d !== 16'h00A5) begin
            errs++; $display("FAIL bounce_stable got %h want 00a5", d);
        end
        repeat (10) @(negedge clk);
        vec++;
        if (sw_changed !== 1'b1) begin
            errs++; $display("FAIL settle_flag got %b want 1", sw_changed);
        end
        bus_read(1, 2'b00, d, lat);
        vec++;
        if (d !== 16'h5A69) begin
            errs++; $display("FAIL settle_lo got %h want 5a69", d);
        end
        bus_read(0, 2'b01, d, lat);
        repeat (10) @(negedge clk);
        vec++;
        if (sw_changed !== 1'b0) begin
            errs++; $display("FAIL single_commit got %b want 0", sw_changed);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sw_raw = 24'h77_BEEF;
        repeat (10) @(negedge clk);
        req0 = 1; addr0 = 2'b00;
        req1 = 1; addr1 = 2'b10;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vec++;
            if (ack0 !== (i % 4 == 0) || ack1 !== (i % 4 == 2)) begin
                errs++;
                $display("FAIL alternate i=%0d got %b%b want %b%b",
                         i, ack0, ack1, (i % 4 == 0), (i % 4 == 2));
            end
            if (i % 4 == 0 && rdata0 !== 16'hBEEF) begin
                errs++; $display("FAIL alt_rd0 i=%0d got %h want beef", i, rdata0);
            end
            if (i % 4 == 2 && rdata1 !== 16'h0077) begin
                errs++; $display("FAIL alt_rd1 i=%0d got %h want 0077", i, rdata1);
            end
        end
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_set_beats_clear();
        logic [15:0] d;
        int          lat;
        sw_raw = 24'h12_3456;
        repeat (5) @(posedge clk);
        @(negedge clk);
        req0 = 1; addr0 = 2'b01;
        @(negedge clk);
        vec++;
        if (ack0 !== 1'b1 || rdata0 !== 16'h0001) begin
            errs++; $display("FAIL race_ack got ack %b rd %h want 1 0001", ack0, rdata0);
        end
        req0 = 0;
        @(negedge clk);
        vec++;
        if (sw_changed !== 1'b1) begin
            errs++; $display("FAIL set_beats_clear got %b want 1", sw_changed);
        end
        bus_read(1, 2'b00, d, lat);
        vec++;
        if (d !== 16'h3456) begin
            errs++; $display("FAIL race_stable got %h want 3456", d);
        end
    endtask

    task automatic test_reset_mid_serve();
        logic [15:0] d;
        int          lat;
        req0 = 1; addr0 = 2'b00;
        @(negedge clk);
        vec++;
        if (ack0 !== 1'b1) begin
            errs++; $display("FAIL pre_reset_ack got %b want 1", ack0);
        end
        rst = 1'b0;
        #1;
        vec++;
        if ({ack0, ack1, sw_changed, rdata0, rdata1} !== 35'd0) begin
            errs++; $display("FAIL mid_reset got %h want 0",
                             {ack0, ack1, sw_changed, rdata0, rdata1});
        end
        req0 = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                errs++; $display("FAIL post_reset_ack i=%0d got %b%b want 00", i, ack0, ack1);
            end
        end
        bus_read(0, 2'b11, d, lat);
        vec++;
        if (d !== 16'h0000 || lat != 1) begin
            errs++; $display("FAIL rd_11 got %h lat %0d want 0000 lat 1", d, lat);
        end
    endtask

    task automatic test_random();
        int r;
        int b;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            vec++;
            if ({ack0, ack1, sw_changed, rdata0, rdata1} !==
                {m_ack0, m_ack1, m_chg, m_rd0, m_rd1}) begin
                errs++;
                $display("FAIL random c=%0d got %b%b%b %h %h want %b%b%b %h %h",
                         c, ack0, ack1, sw_changed, rdata0, rdata1,
                         m_ack0, m_ack1, m_chg, m_rd0, m_rd1);
            end
            if (ack0) req0 = 0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; addr0 = 2'($urandom_range(0, 3));
            end
            if (ack1) req1 = 0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; addr1 = 2'($urandom_range(0, 3));
            end
            r = $urandom_range(0, 15);
            if (r == 0) sw_raw = 24'($urandom);
            else if (r == 1) begin
                b = $urandom_range(0, 23);
                sw_raw[b] = ~sw_raw[b];
            end
            if (c == 400) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_status();
        test_bounce();
        test_back_to_back();
        test_set_beats_clear();
        test_reset_mid_serve();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
